// File: rtl/spi_regbus_arbiter.sv
// Arbitrates a single register bus between an SPI slave front-end and a local requester.
// The SPI side has fixed priority. Every transfer is bounded by a bus_ack timeout.
module spi_regbus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  spi_cs_sync,
    input  logic                  spi_addr_valid,
    input  logic [ADDR_WIDTH-1:0] spi_addr,
    input  logic                  spi_rd_wr,
    input  logic [DATA_WIDTH-1:0] spi_wdata,
    output logic [DATA_WIDTH-1:0] spi_rdata,
    output logic                  spi_done,
    output logic                  spi_err,
    output logic                  spi_overrun,
    input  logic                  loc_req,
    input  logic [ADDR_WIDTH-1:0] loc_addr,
    input  logic                  loc_rd_wr,
    input  logic [DATA_WIDTH-1:0] loc_wdata,
    output logic                  loc_ack,
    output logic [DATA_WIDTH-1:0] loc_rdata,
    output logic                  loc_err,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_rd_wr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StSpiXfer, StLocXfer, StDone} state_e;

    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  spi_pend_q, spi_pend_d;
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic                  cap_rd_wr_q, cap_rd_wr_d;
    logic [DATA_WIDTH-1:0] cap_wdata_q, cap_wdata_d;
    logic [15:0]           xfer_cnt_q, xfer_cnt_d;
    logic                  bus_req_q, bus_req_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic                  bus_rd_wr_q, bus_rd_wr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0] spi_rdata_q, spi_rdata_d;
    logic                  spi_done_q, spi_done_d;
    logic                  spi_err_q, spi_err_d;
    logic                  spi_overrun_q, spi_overrun_d;
    logic [DATA_WIDTH-1:0] loc_rdata_q, loc_rdata_d;
    logic                  loc_ack_q, loc_ack_d;
    logic                  loc_err_q, loc_err_d;
    logic                  busy_q, busy_d;
    logic                  spi_accept;
    logic                  xfer_end;

    assign spi_accept = spi_addr_valid && !spi_cs_sync && !spi_pend_q && (state_q != StSpiXfer);
    assign xfer_end   = bus_ack || (xfer_cnt_q == TmoLast);

    always_comb begin
        state_d       = state_q;
        spi_pend_d    = spi_pend_q;
        cap_addr_d    = cap_addr_q;
        cap_rd_wr_d   = cap_rd_wr_q;
        cap_wdata_d   = cap_wdata_q;
        xfer_cnt_d    = xfer_cnt_q;
        bus_req_d     = bus_req_q;
        bus_addr_d    = bus_addr_q;
        bus_rd_wr_d   = bus_rd_wr_q;
        bus_wdata_d   = bus_wdata_q;
        spi_rdata_d   = spi_rdata_q;
        loc_rdata_d   = loc_rdata_q;
        spi_done_d    = 1'b0;
        spi_err_d     = 1'b0;
        loc_ack_d     = 1'b0;
        loc_err_d     = 1'b0;
        spi_overrun_d = spi_addr_valid && !spi_accept;

        if (spi_accept) begin
            spi_pend_d  = 1'b1;
            cap_addr_d  = spi_addr;
            cap_rd_wr_d = spi_rd_wr;
            cap_wdata_d = spi_wdata;
        end else if (spi_pend_q && spi_cs_sync && (state_q != StSpiXfer)) begin
            // Deselected before the bus was granted: drop the request silently.
            spi_pend_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (spi_accept || (spi_pend_q && !spi_cs_sync)) begin
                    state_d     = StSpiXfer;
                    bus_req_d   = 1'b1;
                    xfer_cnt_d  = '0;
                    bus_addr_d  = spi_accept ? spi_addr  : cap_addr_q;
                    bus_rd_wr_d = spi_accept ? spi_rd_wr : cap_rd_wr_q;
                    bus_wdata_d = spi_accept ? spi_wdata : cap_wdata_q;
                end else if (loc_req) begin
                    state_d     = StLocXfer;
                    bus_req_d   = 1'b1;
                    xfer_cnt_d  = '0;
                    bus_addr_d  = loc_addr;
                    bus_rd_wr_d = loc_rd_wr;
                    bus_wdata_d = loc_wdata;
                end
            end
            StSpiXfer, StLocXfer: begin
                if (xfer_end) begin
                    state_d    = StDone;
                    bus_req_d  = 1'b0;
                    xfer_cnt_d = '0;
                    if (state_q == StSpiXfer) begin
                        spi_done_d = 1'b1;
                        spi_err_d  = !bus_ack;
                        spi_pend_d = 1'b0;
                        if (!bus_ack) begin
                            spi_rdata_d = '0;
                        end else if (bus_rd_wr_q) begin
                            spi_rdata_d = bus_rdata;
                        end
                    end else begin
                        loc_ack_d = 1'b1;
                        loc_err_d = !bus_ack;
                        if (!bus_ack) begin
                            loc_rdata_d = '0;
                        end else if (bus_rd_wr_q) begin
                            loc_rdata_d = bus_rdata;
                        end
                    end
                end else begin
                    xfer_cnt_d = xfer_cnt_q + 16'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            spi_pend_q    <= 1'b0;
            cap_addr_q    <= '0;
            cap_rd_wr_q   <= 1'b0;
            cap_wdata_q   <= '0;
            xfer_cnt_q    <= '0;
            bus_req_q     <= 1'b0;
            bus_addr_q    <= '0;
            bus_rd_wr_q   <= 1'b0;
            bus_wdata_q   <= '0;
            spi_rdata_q   <= '0;
            spi_done_q    <= 1'b0;
            spi_err_q     <= 1'b0;
            spi_overrun_q <= 1'b0;
            loc_rdata_q   <= '0;
            loc_ack_q     <= 1'b0;
            loc_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            spi_pend_q    <= spi_pend_d;
            cap_addr_q    <= cap_addr_d;
            cap_rd_wr_q   <= cap_rd_wr_d;
            cap_wdata_q   <= cap_wdata_d;
            xfer_cnt_q    <= xfer_cnt_d;
            bus_req_q     <= bus_req_d;
            bus_addr_q    <= bus_addr_d;
            bus_rd_wr_q   <= bus_rd_wr_d;
            bus_wdata_q   <= bus_wdata_d;
            spi_rdata_q   <= spi_rdata_d;
            spi_done_q    <= spi_done_d;
            spi_err_q     <= spi_err_d;
            spi_overrun_q <= spi_overrun_d;
            loc_rdata_q   <= loc_rdata_d;
            loc_ack_q     <= loc_ack_d;
            loc_err_q     <= loc_err_d;
            busy_q        <= busy_d;
        end
    end

    assign spi_rdata   = spi_rdata_q;
    assign spi_done    = spi_done_q;
    assign spi_err     = spi_err_q;
    assign spi_overrun = spi_overrun_q;
    assign loc_rdata   = loc_rdata_q;
    assign loc_ack     = loc_ack_q;
    assign loc_err     = loc_err_q;
    assign bus_req     = bus_req_q;
    assign bus_addr    = bus_addr_q;
    assign bus_rd_wr   = bus_rd_wr_q;
    assign bus_wdata   = bus_wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_regbus_arbiter.sv
// Scoreboard bench for spi_regbus_arbiter: the stimulus queues expected events by cycle,
// and a single monitor process compares them against what the DUT presents.
module tb_spi_regbus_arbiter;

    typedef enum int {SigBusReq, SigBusy, SigSpiRdata, SigLocRdata, SigSpiErr} sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] val;
        string       name;
    } pt_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        int          start;
        int          len;
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
    } bus_t;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        spi_cs_sync;
    logic        spi_addr_valid;
    logic [31:0] spi_addr;
    logic        spi_rd_wr;
    logic [31:0] spi_wdata;
    logic [31:0] spi_rdata;
    logic        spi_done;
    logic        spi_err;
    logic        spi_overrun;
    logic        loc_req;
    logic [31:0] loc_addr;
    logic        loc_rd_wr;
    logic [31:0] loc_wdata;
    logic        loc_ack;
    logic [31:0] loc_rdata;
    logic        loc_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_rd_wr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        busy;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          ack_lat = 0;
    logic [31:0] resp_data = '0;
    logic        spur_ack = 1'b0;
    logic        stim_done = 1'b0;

    pt_t  pt_q[$];
    rsp_t spi_q[$];
    rsp_t loc_q[$];
    int   ovr_q[$];
    bus_t bus_q[$];

    spi_regbus_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .spi_cs_sync   (spi_cs_sync),
        .spi_addr_valid(spi_addr_valid),
        .spi_addr      (spi_addr),
        .spi_rd_wr     (spi_rd_wr),
        .spi_wdata     (spi_wdata),
        .spi_rdata     (spi_rdata),
        .spi_done      (spi_done),
        .spi_err       (spi_err),
        .spi_overrun   (spi_overrun),
        .loc_req       (loc_req),
        .loc_addr      (loc_addr),
        .loc_rd_wr     (loc_rd_wr),
        .loc_wdata     (loc_wdata),
        .loc_ack       (loc_ack),
        .loc_rdata     (loc_rdata),
        .loc_err       (loc_err),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_rd_wr     (bus_rd_wr),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .busy          (busy)
    );

    initial forever #5 sys_clk = ~sys_clk;

    // ---------------- checking (monitor is the only process touching the counters)
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] get_sig(input sig_e s);
        case (s)
            SigBusReq:   return {31'd0, bus_req};
            SigBusy:     return {31'd0, busy};
            SigSpiRdata: return spi_rdata;
            SigLocRdata: return loc_rdata;
            SigSpiErr:   return {31'd0, spi_err};
            default:     return '0;
        endcase
    endfunction

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    initial begin
        pt_t  p;
        rsp_t r;
        bus_t cur;
        logic bus_prev;
        int   bus_len;
        bus_prev = 1'b0;
        bus_len  = 0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            for (int i = pt_q.size() - 1; i >= 0; i--) begin
                if (pt_q[i].cyc <= cyc) begin
                    p = pt_q[i];
                    chk(p.name, get_sig(p.sig), p.val);
                    pt_q.delete(i);
                end
            end
            if (spi_done) begin
                if (spi_q.size() == 0) chk("spi_done_unexpected", 32'(spi_done), 32'd0);
                else begin
                    r = spi_q.pop_front();
                    chk("spi_done_cycle", 32'(cyc), 32'(r.cyc));
                    chk("spi_err", 32'(spi_err), 32'(r.err));
                    chk("spi_rdata", spi_rdata, r.rdata);
                end
            end
            if (loc_ack) begin
                if (loc_q.size() == 0) chk("loc_ack_unexpected", 32'(loc_ack), 32'd0);
                else begin
                    r = loc_q.pop_front();
                    chk("loc_ack_cycle", 32'(cyc), 32'(r.cyc));
                    chk("loc_err", 32'(loc_err), 32'(r.err));
                    chk("loc_rdata", loc_rdata, r.rdata);
                end
            end
            if (spi_overrun) begin
                if (ovr_q.size() == 0) chk("overrun_unexpected", 32'(spi_overrun), 32'd0);
                else chk("overrun_cycle", 32'(cyc), 32'(ovr_q.pop_front()));
            end
            if (bus_req && !bus_prev) begin
                if (bus_q.size() == 0) chk("bus_req_unexpected", 32'(bus_req), 32'd0);
                else begin
                    cur = bus_q.pop_front();
                    chk("bus_start_cycle", 32'(cyc), 32'(cur.start));
                    chk("bus_addr", bus_addr, cur.addr);
                    chk("bus_rd_wr", 32'(bus_rd_wr), 32'(cur.rd));
                    chk("bus_wdata", bus_wdata, cur.wdata);
                end
                bus_len = 1;
            end else if (bus_req && bus_prev) begin
                bus_len++;
                chk("bus_addr_stable", bus_addr, cur.addr);
                chk("bus_wdata_stable", bus_wdata, cur.wdata);
            end else if (!bus_req && bus_prev) begin
                chk("bus_req_length", 32'(bus_len), 32'(cur.len));
            end
            bus_prev = bus_req;
            if (stim_done) begin
                chk("spi_events_drained", 32'(spi_q.size()), 32'd0);
                chk("loc_events_drained", 32'(loc_q.size()), 32'd0);
                chk("overrun_events_drained", 32'(ovr_q.size()), 32'd0);
                chk("bus_events_drained", 32'(bus_q.size()), 32'd0);
                chk("point_checks_drained", 32'(pt_q.size()), 32'd0);
                summary();
            end
            if (cyc > 3000) begin
                chk("watchdog_cycle_budget", 32'(cyc), 32'd3000);
                summary();
            end
        end
    end

    // ---------------- bus responder: acks on the ack_lat-th cycle of bus_req (0 = never)
    initial begin
        int bcnt;
        bcnt      = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge sys_clk);
            #2;
            if (bus_req) begin
                bcnt++;
                bus_ack = (ack_lat != 0) && (bcnt == ack_lat);
            end else begin
                bcnt    = 0;
                bus_ack = spur_ack;
            end
            bus_rdata = resp_data;
        end
    end

    // ---------------- stimulus helpers
    function automatic int now_cyc();
        return cyc + 1;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
        spi_addr_valid = 1'b0;
    endtask

    task automatic tick_to(input int c);
        while (now_cyc() < c) tick();
    endtask

    task automatic spi_issue(input logic [31:0] a, input logic rd, input logic [31:0] wd);
        spi_addr_valid = 1'b1;
        spi_addr       = a;
        spi_rd_wr      = rd;
        spi_wdata      = wd;
    endtask

    task automatic exp_pt(input int c, input sig_e s, input logic [31:0] v, input string n);
        pt_t p;
        p.cyc = c; p.sig = s; p.val = v; p.name = n;
        pt_q.push_back(p);
    endtask

    task automatic exp_bus(input int st, input int ln, input logic [31:0] a, input logic rd,
                           input logic [31:0] wd);
        bus_t b;
        b.start = st; b.len = ln; b.addr = a; b.rd = rd; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    task automatic exp_spi(input int c, input logic e, input logic [31:0] d);
        rsp_t r;
        r.cyc = c; r.err = e; r.rdata = d;
        spi_q.push_back(r);
    endtask

    task automatic exp_loc(input int c, input logic e, input logic [31:0] d);
        rsp_t r;
        r.cyc = c; r.err = e; r.rdata = d;
        loc_q.push_back(r);
    endtask

    task automatic spi_read_a5(input logic [31:0] prev_rdata);
        int c0;
        ack_lat   = 3;
        resp_data = 32'hA5A5_A5A5;
        c0 = now_cyc();
        spi_issue(32'h10, 1'b1, 32'h0);
        exp_bus(c0 + 1, 3, 32'h10, 1'b1, 32'h0);
        exp_spi(c0 + 4, 1'b0, 32'hA5A5_A5A5);
        exp_pt(c0 + 1, SigBusy, 32'd1, "busy_in_xfer");
        exp_pt(c0 + 3, SigSpiRdata, prev_rdata, "spi_rdata_before_done");
        exp_pt(c0 + 4, SigBusReq, 32'd0, "bus_req_low_in_done");
        exp_pt(c0 + 5, SigBusReq, 32'd0, "bus_req_low_in_idle");
        exp_pt(c0 + 5, SigBusy, 32'd0, "busy_low_in_idle");
        exp_pt(c0 + 6, SigSpiRdata, 32'hA5A5_A5A5, "spi_rdata_held");
        tick_to(c0 + 8);
    endtask

    // ---------------- directed scenarios
    initial begin
        int c0;
        rstn           = 1'b0;
        spi_cs_sync    = 1'b1;
        spi_addr_valid = 1'b0;
        spi_addr       = '0;
        spi_rd_wr      = 1'b0;
        spi_wdata      = '0;
        loc_req        = 1'b0;
        loc_addr       = '0;
        loc_rd_wr      = 1'b0;
        loc_wdata      = '0;
        tick();
        tick();
        c0 = now_cyc();
        exp_pt(c0, SigBusReq, 32'd0, "reset_bus_req");
        exp_pt(c0, SigBusy, 32'd0, "reset_busy");
        exp_pt(c0, SigSpiRdata, 32'd0, "reset_spi_rdata");
        exp_pt(c0, SigLocRdata, 32'd0, "reset_loc_rdata");
        exp_pt(c0, SigSpiErr, 32'd0, "reset_spi_err");
        tick();
        rstn        = 1'b1;
        spi_cs_sync = 1'b0;
        tick();
        tick();

        // SPI read, ack on the third bus_req cycle
        spi_read_a5(32'h0);

        // SPI write and local read issued together: SPI first, local two cycles after spi_done
        ack_lat   = 2;
        resp_data = 32'h5A5A_0001;
        c0 = now_cyc();
        spi_issue(32'h20, 1'b0, 32'h1111_2222);
        loc_req   = 1'b1;
        loc_addr  = 32'h30;
        loc_rd_wr = 1'b1;
        loc_wdata = 32'h33;
        exp_bus(c0 + 1, 2, 32'h20, 1'b0, 32'h1111_2222);
        exp_spi(c0 + 3, 1'b0, 32'hA5A5_A5A5);
        exp_bus(c0 + 5, 2, 32'h30, 1'b1, 32'h33);
        exp_loc(c0 + 7, 1'b0, 32'h5A5A_0001);
        exp_pt(c0 + 4, SigBusReq, 32'd0, "gap_bus_req");
        exp_pt(c0 + 4, SigBusy, 32'd0, "gap_busy");
        tick_to(c0 + 6);
        loc_addr = 32'hDEAD_0000;
        tick_to(c0 + 8);
        loc_req = 1'b0;
        tick_to(c0 + 11);

        // Timeout: no ack, four bus_req cycles then error completion
        ack_lat = 0;
        c0 = now_cyc();
        spi_issue(32'h40, 1'b1, 32'h0);
        exp_bus(c0 + 1, 4, 32'h40, 1'b1, 32'h0);
        exp_spi(c0 + 5, 1'b1, 32'h0);
        exp_pt(c0 + 6, SigSpiErr, 32'd0, "spi_err_is_pulse");
        exp_pt(c0 + 6, SigSpiRdata, 32'd0, "spi_rdata_zero_after_timeout");
        tick_to(c0 + 9);

        // Overrun during SPI_XFER, plus deselect mid-transfer which must not abort
        ack_lat   = 4;
        resp_data = 32'h0000_BEEF;
        c0 = now_cyc();
        spi_issue(32'h50, 1'b1, 32'h0);
        exp_bus(c0 + 1, 4, 32'h50, 1'b1, 32'h0);
        ovr_q.push_back(c0 + 3);
        exp_spi(c0 + 5, 1'b0, 32'h0000_BEEF);
        tick_to(c0 + 2);
        spi_issue(32'h60, 1'b0, 32'h66);
        tick_to(c0 + 3);
        spi_cs_sync = 1'b1;
        tick_to(c0 + 7);
        spi_cs_sync = 1'b0;
        tick_to(c0 + 10);

        // SPI accepted during a local write, then deselected before grant
        ack_lat = 3;
        c0 = now_cyc();
        loc_req   = 1'b1;
        loc_addr  = 32'h70;
        loc_rd_wr = 1'b0;
        loc_wdata = 32'h7777;
        exp_bus(c0 + 1, 3, 32'h70, 1'b0, 32'h7777);
        exp_loc(c0 + 4, 1'b0, 32'h5A5A_0001);
        exp_pt(c0 + 6, SigBusy, 32'd0, "no_spi_after_deselect");
        exp_pt(c0 + 7, SigBusReq, 32'd0, "no_bus_after_deselect");
        tick();
        spi_issue(32'h80, 1'b1, 32'h0);
        tick();
        spi_cs_sync = 1'b1;
        tick_to(c0 + 5);
        loc_req = 1'b0;
        tick_to(c0 + 8);
        spi_cs_sync = 1'b0;
        tick_to(c0 + 10);

        // SPI pending while a local read runs: served right after it
        ack_lat   = 2;
        resp_data = 32'h1234_5678;
        c0 = now_cyc();
        loc_req   = 1'b1;
        loc_addr  = 32'h90;
        loc_rd_wr = 1'b1;
        loc_wdata = 32'h99;
        exp_bus(c0 + 1, 2, 32'h90, 1'b1, 32'h99);
        exp_loc(c0 + 3, 1'b0, 32'h1234_5678);
        exp_bus(c0 + 5, 2, 32'hA0, 1'b0, 32'hCAFE_0000);
        exp_spi(c0 + 7, 1'b0, 32'h0000_BEEF);
        tick();
        spi_issue(32'hA0, 1'b0, 32'hCAFE_0000);
        tick_to(c0 + 4);
        loc_req = 1'b0;
        tick_to(c0 + 10);

        // Spurious bus_ack while idle is ignored
        spur_ack = 1'b1;
        c0 = now_cyc();
        exp_pt(c0 + 1, SigBusy, 32'd0, "spurious_ack_busy");
        exp_pt(c0 + 2, SigBusReq, 32'd0, "spurious_ack_bus_req");
        tick_to(c0 + 3);
        spur_ack = 1'b0;
        tick_to(c0 + 5);

        // Reset in the middle of a transfer: immediate abort, no completion
        ack_lat = 0;
        c0 = now_cyc();
        spi_issue(32'hB0, 1'b1, 32'h0);
        exp_bus(c0 + 1, 1, 32'hB0, 1'b1, 32'h0);
        tick_to(c0 + 2);
        rstn = 1'b0;
        exp_pt(c0 + 2, SigBusReq, 32'd0, "reset_mid_xfer_bus_req");
        exp_pt(c0 + 2, SigBusy, 32'd0, "reset_mid_xfer_busy");
        exp_pt(c0 + 2, SigSpiRdata, 32'd0, "reset_mid_xfer_spi_rdata");
        exp_pt(c0 + 2, SigLocRdata, 32'd0, "reset_mid_xfer_loc_rdata");
        tick_to(c0 + 5);
        rstn = 1'b1;
        tick_to(c0 + 7);

        // First transaction after reset behaves like the one after power-up
        spi_read_a5(32'h0);

        tick_to(now_cyc() + 3);
        stim_done = 1'b1;
    end

endmodule

// File: doc/spi_regbus_arbiter.md
SPI_REGBUS_ARBITER -- requirements
Module: spi_regbus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles waiting for bus_ack (range 1..65535).
REQ-004 SHALL have port sys_clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port spi_cs_sync  in  1  synchronized SPI chip select, active-low.
REQ-007 SHALL have port spi_addr_valid  in  1  one-cycle pulse, SPI access request.
REQ-008 SHALL have ports spi_addr  in  ADDR_WIDTH, spi_rd_wr  in  1 (1=read, 0=write), spi_wdata  in  DATA_WIDTH; all qualified by spi_addr_valid.
REQ-009 SHALL have outputs spi_rdata  DATA_WIDTH, spi_done  1 (completion pulse), spi_err  1 (timeout, valid with spi_done), spi_overrun  1 (pulse, request dropped).
REQ-010 SHALL have local port loc_req  in  1 (level), loc_addr  in  ADDR_WIDTH, loc_rd_wr  in  1, loc_wdata  in  DATA_WIDTH.
REQ-011 SHALL have outputs loc_ack  1 (completion pulse), loc_rdata  DATA_WIDTH, loc_err  1 (valid with loc_ack).
REQ-012 SHALL have bus outputs bus_req  1, bus_addr  ADDR_WIDTH, bus_rd_wr  1, bus_wdata  DATA_WIDTH; inputs bus_ack  1, bus_rdata  DATA_WIDTH.
REQ-013 SHALL have output busy  1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SPI_XFER, LOC_XFER, DONE; all outputs registered.
REQ-015 SHALL capture spi_addr/spi_rd_wr/spi_wdata on any accepted spi_addr_valid cycle and set spi_pend.
REQ-016 SHALL accept spi_addr_valid only when spi_cs_sync=0 and spi_pend=0 and state is not SPI_XFER; otherwise pulse spi_overrun next cycle and keep prior capture.
REQ-017 SHALL clear spi_pend without bus access if spi_cs_sync goes 1 before grant; no spi_done issued.
REQ-018 IDLE: spi_pend or accepted spi_addr_valid -> SPI_XFER; else loc_req=1 -> LOC_XFER; SPI has fixed priority.
REQ-019 SHALL assert bus_req on first cycle of an XFER state (one cycle after the pulse when IDLE) and hold bus_addr/bus_rd_wr/bus_wdata stable until exit.
REQ-020 SHALL load local fields from loc_* on IDLE->LOC_XFER; loc_* changes afterwards ignored.
REQ-021 XFER: bus_ack=1 -> DONE, bus_req=0 next cycle, read data registered from bus_rdata when rd_wr=1.
REQ-022 SHALL count XFER cycles; count reaching TIMEOUT without bus_ack -> DONE with err=1, rdata=0, bus_req=0.
REQ-023 DONE lasts exactly one cycle: spi_done or loc_ack=1 for the owner, err/rdata valid; then IDLE.
REQ-024 spi_rdata/loc_rdata SHALL hold last value until next completion of that owner; writes leave rdata unchanged.
REQ-025 bus_req SHALL be low for at least 2 cycles (DONE, IDLE) between transactions.
REQ-026 bus_ack in IDLE or DONE SHALL be ignored.
REQ-027 Local requester SHALL drop loc_req on the cycle after loc_ack; loc_req still high in following IDLE = new request.
REQ-028 spi_cs_sync rising during SPI_XFER SHALL NOT abort; transaction completes and spi_done still pulses.
REQ-029 spi_pend cleared on DONE of SPI transaction; loc_req arriving with spi_pend waits.

Reset
REQ-030 rstn=0 SHALL force IDLE immediately, spi_pend=0, counter=0, all outputs 0, including in-flight transfer (no done/ack issued).
REQ-031 After rstn release, first transaction SHALL behave identically to power-up.

Verification
REQ-032 SPI read: pulse at cycle 0, addr 0x10, bus_ack at cycle 3 with 0xA5A5A5A5 -> bus_req cycles 1-3, spi_done + spi_rdata=0xA5A5A5A5 cycle 4, spi_err=0.
REQ-033 Contention: loc_req and spi pulse same IDLE cycle -> SPI served first, LOC_XFER begins 2 cycles after spi_done, loc_ack follows.
REQ-034 Timeout: TIMEOUT=4, bus_ack never -> bus_req 4 cycles, then spi_done=1, spi_err=1, spi_rdata=0.
REQ-035 Overrun: second spi pulse during SPI_XFER -> spi_overrun 1-cycle pulse, bus_addr unchanged, single spi_done.
REQ-036 Deselect/reset: pulse during LOC_XFER then spi_cs_sync=1 before grant -> no SPI bus access; rstn low mid-XFER -> bus_req=0 same cycle, no ack.
